// File: rtl/chacha_pkg.sv
// Shared types and helpers for the small-scale ChaCha block core.
// FSM encoding, default word/rotation constants and word-quadruple index helpers.
package chacha_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COL   = 2'd1,
        DIAG  = 2'd2,
        FINAL = 2'd3
    } state_e;

    localparam int CHACHA_W = 8;
    localparam int QR_R1    = 4;
    localparam int QR_R2    = 3;
    localparam int QR_R3    = 2;
    localparam int QR_R4    = 1;

    // Word index of row `row` in column k: rows are 4 words apart.
    function automatic logic [3:0] col_idx(input logic [1:0] k, input logic [1:0] row);
        return {row, k};
    endfunction

    // Diagonal k walks one column right per row, wrapping modulo 4.
    function automatic logic [3:0] diag_idx(input logic [1:0] k, input logic [1:0] row);
        logic [1:0] c;
        c = k + row;
        return {row, c};
    endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// Combinational ChaCha quarter-round on four W-bit words.
// Zero latency; no flow control.
module chacha_quarter_round #(
    parameter int W  = 8,
    parameter int R1 = 4,
    parameter int R2 = 3,
    parameter int R3 = 2,
    parameter int R4 = 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic [W-1:0] c_o,
    output logic [W-1:0] d_o
);

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int r);
        return (x << r) | (x >> (W - r));
    endfunction

    logic [W-1:0] a1, b1, c1, d1;

    always_comb begin
        a1  = a_i + b_i;
        d1  = rotl(d_i ^ a1, R1);
        c1  = c_i + d1;
        b1  = rotl(b_i ^ c1, R2);
        a_o = a1 + b1;
        d_o = rotl(d1 ^ a_o, R3);
        c_o = c1 + d_o;
        b_o = rotl(b1 ^ c_o, R4);
    end

endmodule

// File: rtl/chacha_block_core.sv
// ChaCha block function: one quarter-round per cycle over ROUNDS double rounds, then feed-forward add.
// done pulses 8*ROUNDS+1 edges after start acceptance; start is ignored while busy (no stall path).
module chacha_block_core
    import chacha_pkg::*;
#(
    parameter int W      = CHACHA_W,
    parameter int ROUNDS = 4,
    parameter int R1     = QR_R1,
    parameter int R2     = QR_R2,
    parameter int R3     = QR_R3,
    parameter int R4     = QR_R4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [16*W-1:0] state_in,
    output logic            busy,
    output logic            done,
    output logic [16*W-1:0] state_out
);

    localparam int RW = $clog2(ROUNDS + 1);

    state_e          state_q, state_d;
    logic [1:0]      qidx_q, qidx_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic [W-1:0]    work_q [16];
    logic [W-1:0]    work_d [16];
    logic [W-1:0]    init_q [16];
    logic [W-1:0]    init_d [16];
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [16*W-1:0] out_q, out_d;

    logic [3:0]      ia, ib, ic, id;
    logic [W-1:0]    qa, qb, qc, qd;
    logic            last_qr, last_rnd;

    assign last_qr  = (qidx_q == 2'd3);
    assign last_rnd = (rnd_q == RW'(ROUNDS - 1));

    // Column and diagonal passes share one quarter-round unit through these selects.
    always_comb begin
        if (state_q == DIAG) begin
            ia = diag_idx(qidx_q, 2'd0);
            ib = diag_idx(qidx_q, 2'd1);
            ic = diag_idx(qidx_q, 2'd2);
            id = diag_idx(qidx_q, 2'd3);
        end else begin
            ia = col_idx(qidx_q, 2'd0);
            ib = col_idx(qidx_q, 2'd1);
            ic = col_idx(qidx_q, 2'd2);
            id = col_idx(qidx_q, 2'd3);
        end
    end

    chacha_quarter_round #(.W(W), .R1(R1), .R2(R2), .R3(R3), .R4(R4)) u_qr (
        .a_i (work_q[ia]),
        .b_i (work_q[ib]),
        .c_i (work_q[ic]),
        .d_i (work_q[id]),
        .a_o (qa),
        .b_o (qb),
        .c_o (qc),
        .d_o (qd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COL;
            COL:     if (last_qr) state_d = DIAG;
            DIAG:    if (last_qr) state_d = last_rnd ? FINAL : COL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        qidx_d = qidx_q;
        rnd_d  = rnd_q;
        busy_d = busy_q;
        done_d = 1'b0;
        out_d  = out_q;
        for (int i = 0; i < 16; i++) begin
            work_d[i] = work_q[i];
            init_d[i] = init_q[i];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) begin
                        work_d[i] = state_in[i*W +: W];
                        init_d[i] = state_in[i*W +: W];
                    end
                    qidx_d = 2'd0;
                    rnd_d  = '0;
                    busy_d = 1'b1;
                end
            end
            COL, DIAG: begin
                for (int i = 0; i < 16; i++) begin
                    if (4'(i) == ia) work_d[i] = qa;
                    if (4'(i) == ib) work_d[i] = qb;
                    if (4'(i) == ic) work_d[i] = qc;
                    if (4'(i) == id) work_d[i] = qd;
                end
                qidx_d = qidx_q + 2'd1;
                if (state_q == DIAG && last_qr) rnd_d = rnd_q + 1'b1;
            end
            FINAL: begin
                for (int i = 0; i < 16; i++) out_d[i*W +: W] = work_q[i] + init_q[i];
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qidx_q <= '0;
            rnd_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            out_q  <= '0;
            for (int i = 0; i < 16; i++) begin
                work_q[i] <= '0;
                init_q[i] <= '0;
            end
        end else begin
            qidx_q <= qidx_d;
            rnd_q  <= rnd_d;
            busy_q <= busy_d;
            done_q <= done_d;
            out_q  <= out_d;
            for (int i = 0; i < 16; i++) begin
                work_q[i] <= work_d[i];
                init_q[i] <= init_d[i];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = out_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Bench for chacha_block_core (ROUNDS=4 and ROUNDS=1 instances) plus the quarter-round unit,
// checked against an array-based ChaCha reference model.
module tb_chacha_block_core;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start4 = 1'b0, start1 = 1'b0;
    logic [127:0] in4 = '0, in1 = '0;
    logic         busy4, done4, busy1, done1;
    logic [127:0] out4, out1;
    logic [7:0]   qa_i = '0, qb_i = '0, qc_i = '0, qd_i = '0;
    logic [7:0]   qa_o, qb_o, qc_o, qd_o;

    int checks = 0;
    int errors = 0;
    int done_total4 = 0;
    int done_total1 = 0;

    always #5 clk = ~clk;

    chacha_block_core #(.W(8), .ROUNDS(4), .R1(4), .R2(3), .R3(2), .R4(1)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .state_in(in4),
        .busy(busy4), .done(done4), .state_out(out4)
    );

    chacha_block_core #(.W(8), .ROUNDS(1), .R1(4), .R2(3), .R3(2), .R4(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .state_in(in1),
        .busy(busy1), .done(done1), .state_out(out1)
    );

    chacha_quarter_round #(.W(8), .R1(4), .R2(3), .R3(2), .R4(1)) uqr (
        .a_i(qa_i), .b_i(qb_i), .c_i(qc_i), .d_i(qd_i),
        .a_o(qa_o), .b_o(qb_o), .c_o(qc_o), .d_o(qd_o)
    );

    always @(negedge clk) begin
        if (done4) done_total4++;
        if (done1) done_total1++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int r);
        logic [15:0] t;
        t = {x, x} << r;
        return t[15:8];
    endfunction

    function automatic logic [31:0] qr_ref(input logic [7:0] a, b, c, d);
        a = a + b; d = rotl8(d ^ a, 4);
        c = c + d; b = rotl8(b ^ c, 3);
        a = a + b; d = rotl8(d ^ a, 2);
        c = c + d; b = rotl8(b ^ c, 1);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] s, input int dr);
        logic [7:0]   x [16];
        logic [31:0]  r;
        logic [127:0] o;
        int           p [4];
        for (int i = 0; i < 16; i++) x[i] = s[i*8 +: 8];
        for (int n = 0; n < dr; n++) begin
            for (int pass = 0; pass < 2; pass++) begin
                for (int k = 0; k < 4; k++) begin
                    for (int row = 0; row < 4; row++)
                        p[row] = 4 * row + ((k + pass * row) % 4);
                    r = qr_ref(x[p[0]], x[p[1]], x[p[2]], x[p[3]]);
                    x[p[0]] = r[31:24]; x[p[1]] = r[23:16];
                    x[p[2]] = r[15:8];  x[p[3]] = r[7:0];
                end
            end
        end
        for (int i = 0; i < 16; i++) o[i*8 +: 8] = x[i] + s[i*8 +: 8];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Pulses start for one cycle; lat = edges from acceptance to done, -1 on timeout.
    task automatic run(input bit sel1, input logic [127:0] v, output int lat, output int bcnt);
        @(negedge clk);
        if (sel1) begin in1 = v; start1 = 1'b1; end
        else      begin in4 = v; start4 = 1'b1; end
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        bcnt = (sel1 ? busy1 : busy4) ? 1 : 0;
        lat = -1;
        for (int k = 2; k <= 100 && lat < 0; k++) begin
            @(negedge clk);
            if (sel1 ? done1 : done4) lat = k - 1;
            else if (sel1 ? busy1 : busy4) bcnt++;
        end
    endtask

    initial begin
        int           lat, bcnt, d0;
        logic [127:0] v, v2, exp_v;
        logic [31:0]  qexp;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy4, 1'b0);
        check("rst_done", done4, 1'b0);
        check("rst_out", out4, 128'h0);
        reset = 1'b0;

        // Quarter-round unit: known vector and a random one
        qa_i = 8'h01; qb_i = 8'h00; qc_i = 8'h00; qd_i = 8'h00;
        #1;
        check("qr_a", qa_o, 8'h81);
        check("qr_b", qb_o, 8'hAD);
        check("qr_c", qc_o, 8'h56);
        check("qr_d", qd_o, 8'h46);
        {qa_i, qb_i, qc_i, qd_i} = $urandom;
        #1;
        qexp = qr_ref(qa_i, qb_i, qc_i, qd_i);
        check("qr_rand", {qa_o, qb_o, qc_o, qd_o}, qexp);

        // All-zero block
        d0 = done_total4;
        run(1'b0, 128'h0, lat, bcnt);
        check("zero_lat", lat, 33);
        check("zero_busy", bcnt, 33);
        check("zero_out", out4, 128'h0);
        @(negedge clk);
        check("zero_done_cnt", done_total4 - d0, 1);

        // Random blocks, 4 and 1 double rounds
        for (int t = 0; t < 3; t++) begin
            v = rand128();
            run(1'b0, v, lat, bcnt);
            check("r4_lat", lat, 33);
            check("r4_out", out4, ref_block(v, 4));
            v = rand128();
            run(1'b1, v, lat, bcnt);
            check("r1_lat", lat, 9);
            check("r1_out", out1, ref_block(v, 1));
        end

        // Start pulses while busy are ignored
        v = rand128();
        d0 = done_total4;
        @(negedge clk); in4 = v; start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k <= 25 && (k % 5) == 0) begin start4 = 1'b1; in4 = rand128(); end
            else start4 = 1'b0;
        end
        check("ign_done_cnt", done_total4 - d0, 1);
        check("ign_out", out4, ref_block(v, 4));

        // Reset mid-run
        @(negedge clk); in4 = rand128(); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1; #1;
        check("mid_rst_busy", busy4, 1'b0);
        check("mid_rst_done", done4, 1'b0);
        check("mid_rst_out", out4, 128'h0);
        @(negedge clk); reset = 1'b0;
        d0 = done_total4;
        repeat (50) @(negedge clk);
        check("mid_rst_no_done", done_total4 - d0, 0);

        // start held high across done: back-to-back runs
        v = rand128(); v2 = rand128();
        exp_v = ref_block(v, 4);
        @(negedge clk); in4 = v; start4 = 1'b1;
        lat = -1;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(negedge clk);
            if (done4) lat = k - 1;
        end
        check("b2b_lat1", lat, 33);
        check("b2b_out1", out4, exp_v);
        in4 = v2;
        @(negedge clk); start4 = 1'b0;
        check("b2b_busy", busy4, 1'b1);
        check("b2b_done_low", done4, 1'b0);
        check("b2b_out_held", out4, exp_v);
        lat = -1;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(negedge clk);
            if (done4) lat = k;
        end
        check("b2b_lat2", lat, 33);
        check("b2b_out2", out4, ref_block(v2, 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
